// File: rtl/adder_sched.sv
// adder_sched: two-port valid/ready scheduler sharing one fixed-latency double-precision add/sub datapath.
// Build option ADDER_SCHED_RR_EN selects round-robin tie-breaking; undefined gives fixed port-0 priority.
module adder_sched #(
    parameter int unsigned LAT = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    req_valid,
    output logic [1:0]    req_ready,
    input  logic [127:0]  req_fpa,
    input  logic [127:0]  req_fpb,
    input  logic [1:0]    req_sub,
    input  logic [1:0]    req_db,
    input  logic [3:0]    req_rm,
    output logic          dp_valid,
    output logic [63:0]   dp_fpa,
    output logic [63:0]   dp_fpb,
    output logic          dp_sub,
    output logic          dp_db,
    output logic [1:0]    dp_rm,
    input  logic          dp_ss,
    input  logic [10:0]   dp_es,
    input  logic [56:0]   dp_fs,
    input  logic [57:0]   dp_fls,
    output logic [1:0]    rsp_valid,
    input  logic [1:0]    rsp_ready,
    output logic          rsp_ss,
    output logic [10:0]   rsp_es,
    output logic [56:0]   rsp_fs,
    output logic [57:0]   rsp_fls,
    output logic          busy,
    output logic [1:0]    dbg_state
);

    // Handshakes: a transfer occurs on port N in any cycle where valid[N] and ready[N] are both high;
    // the source holds valid and data until then. req_ready is only ever raised in IDLE, rsp_valid only in RESP.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] LAT_L = 4'(LAT);

    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [63:0]   opa_q, opa_d;
    logic [63:0]   opb_q, opb_d;
    logic          sub_q, sub_d;
    logic          db_q, db_d;
    logic [1:0]    rm_q, rm_d;
    logic          ss_q, ss_d;
    logic [10:0]   es_q, es_d;
    logic [56:0]   fs_q, fs_d;
    logic [57:0]   fls_q, fls_d;
    logic          gnt_port;

`ifdef ADDER_SCHED_RR_EN
    logic          last_q, last_d;
`endif

    always_comb begin
        gnt_port = 1'b0;
        if (req_valid == 2'b10) begin
            gnt_port = 1'b1;
        end
`ifdef ADDER_SCHED_RR_EN
        else if (req_valid == 2'b11) begin
            gnt_port = ~last_q;
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        sub_d     = sub_q;
        db_d      = db_q;
        rm_d      = rm_q;
        ss_d      = ss_q;
        es_d      = es_q;
        fs_d      = fs_q;
        fls_d     = fls_q;
        req_ready = 2'b00;
`ifdef ADDER_SCHED_RR_EN
        last_d    = last_q;
`endif
        unique case (state_q)
            IDLE: begin
                // Ready is gated by reset so every output reads 0 while rst_n is low.
                if (rst_n && (|req_valid)) begin
                    req_ready[gnt_port] = 1'b1;
                    owner_d = gnt_port;
                    opa_d   = gnt_port ? req_fpa[127:64] : req_fpa[63:0];
                    opb_d   = gnt_port ? req_fpb[127:64] : req_fpb[63:0];
                    sub_d   = req_sub[gnt_port];
                    db_d    = req_db[gnt_port];
                    rm_d    = gnt_port ? req_rm[3:2] : req_rm[1:0];
                    cnt_d   = LAT_L;
                    state_d = EXEC;
`ifdef ADDER_SCHED_RR_EN
                    last_d  = gnt_port;
`endif
                end
            end
            EXEC: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    ss_d    = dp_ss;
                    es_d    = dp_es;
                    fs_d    = dp_fs;
                    fls_d   = dp_fls;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready[owner_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            cnt_q   <= 4'd0;
            opa_q   <= 64'd0;
            opb_q   <= 64'd0;
            sub_q   <= 1'b0;
            db_q    <= 1'b0;
            rm_q    <= 2'd0;
            ss_q    <= 1'b0;
            es_q    <= 11'd0;
            fs_q    <= 57'd0;
            fls_q   <= 58'd0;
`ifdef ADDER_SCHED_RR_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            sub_q   <= sub_d;
            db_q    <= db_d;
            rm_q    <= rm_d;
            ss_q    <= ss_d;
            es_q    <= es_d;
            fs_q    <= fs_d;
            fls_q   <= fls_d;
`ifdef ADDER_SCHED_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    assign dp_valid  = (state_q == EXEC);
    assign dp_fpa    = opa_q;
    assign dp_fpb    = opb_q;
    assign dp_sub    = sub_q;
    assign dp_db     = db_q;
    assign dp_rm     = rm_q;
    assign rsp_valid = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_ss    = ss_q;
    assign rsp_es    = es_q;
    assign rsp_fs    = fs_q;
    assign rsp_fls   = fls_q;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_adder_sched.sv
// tb_adder_sched: scoreboard bench for adder_sched; main instance at LAT=3, second instance at LAT=1.
// The bench follows ADDER_SCHED_RR_EN to pick the expected tie-break policy.
`timescale 1ns/1ps
module tb_adder_sched;

    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]   req_valid = '0, req_ready, req_sub = '0, req_db = '0, rsp_valid, rsp_ready = '0, dbg_state;
    logic [127:0] req_fpa = '0, req_fpb = '0;
    logic [3:0]   req_rm = '0;
    logic         dp_valid, dp_sub, dp_db, dp_ss, rsp_ss, busy;
    logic [63:0]  dp_fpa, dp_fpb;
    logic [1:0]   dp_rm;
    logic [10:0]  dp_es, rsp_es;
    logic [56:0]  dp_fs, rsp_fs;
    logic [57:0]  dp_fls, rsp_fls;

    // Black-box datapath stand-in: a cheap function of every operand field.
    function automatic logic [126:0] dp_model(input logic [63:0] a, input logic [63:0] b,
                                              input logic s, input logic d, input logic [1:0] r);
        logic [10:0] e;
        e = a[62:52] + {10'd0, ~s};
        dp_model = {a[63], e, 1'b1, a[51:0] ^ b[51:0], r, d, s, b[63:6]};
    endfunction

    // Result is valid only in the LAT-th cycle of dp_valid; other cycles carry the inverted value.
    logic [3:0]   dv_cnt = '0;
    logic [126:0] dp_good;
    always @(posedge clk) dv_cnt <= dp_valid ? dv_cnt + 4'd1 : 4'd0;
    assign dp_good = dp_model(dp_fpa, dp_fpb, dp_sub, dp_db, dp_rm);
    assign {dp_ss, dp_es, dp_fs, dp_fls} = (dp_valid && dv_cnt == 4'(LAT - 1)) ? dp_good : ~dp_good;

    adder_sched #(.LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_fpa(req_fpa), .req_fpb(req_fpb),
        .req_sub(req_sub), .req_db(req_db), .req_rm(req_rm),
        .dp_valid(dp_valid), .dp_fpa(dp_fpa), .dp_fpb(dp_fpb), .dp_sub(dp_sub), .dp_db(dp_db), .dp_rm(dp_rm),
        .dp_ss(dp_ss), .dp_es(dp_es), .dp_fs(dp_fs), .dp_fls(dp_fls),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ss(rsp_ss), .rsp_es(rsp_es),
        .rsp_fs(rsp_fs), .rsp_fls(rsp_fls), .busy(busy), .dbg_state(dbg_state)
    );

    // LAT=1 instance
    logic [1:0]   l1_req_valid = '0, l1_req_ready, l1_req_sub = '0, l1_req_db = '0, l1_rsp_valid, l1_rsp_ready = '0, l1_dbg_state;
    logic [127:0] l1_req_fpa = '0, l1_req_fpb = '0;
    logic [3:0]   l1_req_rm = '0;
    logic         l1_dp_valid, l1_dp_sub, l1_dp_db, l1_dp_ss, l1_rsp_ss, l1_busy;
    logic [63:0]  l1_dp_fpa, l1_dp_fpb;
    logic [1:0]   l1_dp_rm;
    logic [10:0]  l1_dp_es, l1_rsp_es;
    logic [56:0]  l1_dp_fs, l1_rsp_fs;
    logic [57:0]  l1_dp_fls, l1_rsp_fls;
    logic [126:0] l1_good;

    assign l1_good = dp_model(l1_dp_fpa, l1_dp_fpb, l1_dp_sub, l1_dp_db, l1_dp_rm);
    assign {l1_dp_ss, l1_dp_es, l1_dp_fs, l1_dp_fls} = l1_dp_valid ? l1_good : ~l1_good;

    adder_sched #(.LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(l1_req_valid), .req_ready(l1_req_ready), .req_fpa(l1_req_fpa), .req_fpb(l1_req_fpb),
        .req_sub(l1_req_sub), .req_db(l1_req_db), .req_rm(l1_req_rm),
        .dp_valid(l1_dp_valid), .dp_fpa(l1_dp_fpa), .dp_fpb(l1_dp_fpb), .dp_sub(l1_dp_sub), .dp_db(l1_dp_db),
        .dp_rm(l1_dp_rm), .dp_ss(l1_dp_ss), .dp_es(l1_dp_es), .dp_fs(l1_dp_fs), .dp_fls(l1_dp_fls),
        .rsp_valid(l1_rsp_valid), .rsp_ready(l1_rsp_ready), .rsp_ss(l1_rsp_ss), .rsp_es(l1_rsp_es),
        .rsp_fs(l1_rsp_fs), .rsp_fls(l1_rsp_fls), .busy(l1_busy), .dbg_state(l1_dbg_state)
    );

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: {port, result} pushed at request handshake, popped at response handshake.
    logic [127:0] exp_q[$];
    logic         gnt_log[$];
    int           rsp_cnt = 0;
    logic         mon_g, mon_eg;
    logic [127:0] mon_e;
`ifdef ADDER_SCHED_RR_EN
    logic         rr_last = 1'b1;
`endif

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
`ifdef ADDER_SCHED_RR_EN
            rr_last = 1'b1;
`endif
        end else begin
            if (|(req_valid & req_ready)) begin
                mon_g  = req_ready[1];
                mon_eg = (req_valid == 2'b10);
`ifdef ADDER_SCHED_RR_EN
                if (req_valid == 2'b11) mon_eg = ~rr_last;
                rr_last = mon_g;
`endif
                check("grant", {127'd0, mon_g}, {127'd0, mon_eg});
                gnt_log.push_back(mon_g);
                if (mon_g)
                    exp_q.push_back({1'b1, dp_model(req_fpa[127:64], req_fpb[127:64], req_sub[1], req_db[1], req_rm[3:2])});
                else
                    exp_q.push_back({1'b0, dp_model(req_fpa[63:0], req_fpb[63:0], req_sub[0], req_db[0], req_rm[1:0])});
            end
            if (|(rsp_valid & rsp_ready)) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", {126'd0, rsp_valid}, 128'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rsp_port", {126'd0, rsp_valid}, mon_e[127] ? 128'd2 : 128'd1);
                    check("rsp_data", {1'b0, rsp_ss, rsp_es, rsp_fs, rsp_fls}, {1'b0, mon_e[126:0]});
                    rsp_cnt++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic [63:0] a, input logic [63:0] b,
                           input logic s, input logic d, input logic [1:0] r);
        if (p == 0) begin
            req_fpa[63:0] = a; req_fpb[63:0] = b; req_sub[0] = s; req_db[0] = d; req_rm[1:0] = r;
            req_valid[0] = 1'b1;
        end else begin
            req_fpa[127:64] = a; req_fpb[127:64] = b; req_sub[1] = s; req_db[1] = d; req_rm[3:2] = r;
            req_valid[1] = 1'b1;
        end
    endtask

    task automatic set_rand_req(input int p);
        set_req(p, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {119'd0, dp_valid, dp_sub, dp_db, dp_rm, req_ready, rsp_valid, busy}, 128'd0);
        check(tag, {dp_fpa, dp_fpb}, 128'd0);
        check(tag, {1'b0, rsp_ss, rsp_es, rsp_fs, rsp_fls}, 128'd0);
        check(tag, {126'd0, dbg_state}, 128'd0);
    endtask

    task automatic wait_rsp(input int target, input int budget);
        int n;
        n = 0;
        while (rsp_cnt < target && n < budget) begin
            step();
            n++;
        end
        check("rsp_timeout", {127'd0, rsp_cnt >= target}, 128'd1);
    endtask

    localparam logic [63:0] THREE = 64'h4008000000000000;
    logic [126:0] three_res;
    logic [1:0]   hs;
    logic         saw_r1;
    int           base, cyc, prev, n_acc, n_dv;

    initial begin
        // Reset state
        rst_n = 1'b0;
        req_valid = 2'b01;
        repeat (2) step();
        @(negedge clk);
        check_all_zero("reset_outputs");
        step();
        rst_n = 1'b1;

        // Single operation on port 0, LAT=3
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        set_req(0, THREE, THREE, 1'b0, 1'b1, 2'd0);
        three_res = dp_model(THREE, THREE, 1'b0, 1'b1, 2'd0);
        @(negedge clk);
        check("c0_ready", {126'd0, req_ready}, 128'd1);
        check("c0_dp_valid", {127'd0, dp_valid}, 128'd0);
        step();
        req_valid = 2'b00;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            check("exec_dp_valid", {127'd0, dp_valid}, 128'd1);
            check("exec_dp_ops", {dp_fpa, dp_fpb}, {THREE, THREE});
            check("exec_ready", {126'd0, req_ready, busy}, 128'd1);
            step();
        end
        @(negedge clk);
        check("c4_rsp_valid", {126'd0, rsp_valid}, 128'd1);
        check("c4_rsp_es", {116'd0, rsp_ss, rsp_es}, {116'd0, 1'b0, 11'h401});
        check("c4_model_es", {117'd0, three_res[125:115]}, {117'd0, 11'h401});
        check("c4_dp_valid", {127'd0, dp_valid}, 128'd0);
        step();
        @(negedge clk);
        check("c5_idle", {125'd0, busy, rsp_valid}, 128'd0);

        // Simultaneous requests on both ports
        do_reset();
        gnt_log.delete();
        base = rsp_cnt;
        saw_r1 = 1'b0;
        rsp_ready = 2'b11;
        set_rand_req(0);
        set_rand_req(1);
        cyc = 0;
        while (gnt_log.size() < 4 && cyc < 200) begin
            @(negedge clk);
            hs = req_valid & req_ready;
            if (req_ready[1]) saw_r1 = 1'b1;
            step();
            if (hs[0]) set_rand_req(0);
            if (hs[1]) set_rand_req(1);
            cyc++;
        end
        req_valid = 2'b00;
        wait_rsp(base + 4, 100);
        check("tie_grants", gnt_log.size(), 128'd4);
        for (int i = 0; i < 4 && i < gnt_log.size(); i++) begin
`ifdef ADDER_SCHED_RR_EN
            check("tie_seq", {127'd0, gnt_log[i]}, {127'd0, 1'(i % 2)});
`else
            check("tie_seq", {127'd0, gnt_log[i]}, 128'd0);
`endif
        end
`ifdef ADDER_SCHED_RR_EN
        check("tie_port1_ready", {127'd0, saw_r1}, 128'd1);
`else
        check("tie_port1_ready", {127'd0, saw_r1}, 128'd0);
`endif

        // Response backpressure with port 1 waiting; non-owner rsp_ready must be ignored
        do_reset();
        base = rsp_cnt;
        rsp_ready = 2'b10;
        set_rand_req(0);
        @(negedge clk);
        check("bp_ready0", {126'd0, req_ready}, 128'd1);
        step();
        req_valid = 2'b00;
        set_rand_req(1);
        @(negedge clk);
        cyc = 0;
        while (rsp_valid == 2'b00 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            check("bp_rsp_valid", {126'd0, rsp_valid}, 128'd1);
            check("bp_rsp_data", {1'b0, rsp_ss, rsp_es, rsp_fs, rsp_fls},
                  exp_q.size() > 0 ? {1'b0, exp_q[0][126:0]} : 128'd0);
            check("bp_busy_ready", {125'd0, busy, req_ready}, 128'd4);
        end
        step();
        rsp_ready = 2'b11;
        @(negedge clk);
        step();
        @(negedge clk);
        check("bp_next_grant", {126'd0, req_ready}, 128'd2);
        step();
        req_valid = 2'b00;
        wait_rsp(base + 2, 40);

        // Reset in EXEC cycle 2 drops the operation
        do_reset();
        rsp_ready = 2'b11;
        set_rand_req(0);
        step();
        req_valid = 2'b00;
        set_rand_req(1);
        step();
        rst_n = 1'b0;
        step();
        @(negedge clk);
        check_all_zero("mid_reset");
        base = rsp_cnt;
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_grant", {126'd0, req_ready}, 128'd2);
        step();
        req_valid = 2'b00;
        wait_rsp(base + 1, 40);
        repeat (4) step();
        check("post_reset_rsp_count", rsp_cnt - base, 128'd1);

        // LAT=1: back-to-back port 0 requests
        l1_rsp_ready = 2'b11;
        l1_req_fpa = {64'd0, THREE};
        l1_req_fpb = {64'd0, 64'h3ff0000000000000};
        l1_req_sub = 2'b01;
        l1_req_db = 2'b01;
        l1_req_rm = 4'd2;
        step();
        l1_req_valid = 2'b01;
        prev = -1;
        n_acc = 0;
        n_dv = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (l1_dp_valid) n_dv++;
            if (l1_req_ready[0]) begin
                if (prev >= 0) check("l1_spacing", c - prev, 128'd3);
                prev = c;
                n_acc++;
            end
            if (l1_rsp_valid != 2'b00) begin
                check("l1_rsp_valid", {126'd0, l1_rsp_valid}, 128'd1);
                check("l1_rsp_data", {1'b0, l1_rsp_ss, l1_rsp_es, l1_rsp_fs, l1_rsp_fls},
                      {1'b0, dp_model(THREE, 64'h3ff0000000000000, 1'b1, 1'b1, 2'd2)});
            end
        end
        l1_req_valid = 2'b00;
        check("l1_accepts", n_acc, 128'd4);
        check("l1_dp_valid_cycles", n_dv, 128'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
